// File: rtl/maze_plan_if.sv
// Handshake and motion-control bundle between the UART wrapper/line-follow side and maze_plan_seq.
// The fault signal exists only when MAZE_PLAN_TIMEOUT_EN is defined.
interface maze_plan_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        line_present;
  logic        bmp;
  logic        go;
  logic        veer_rght;
  logic        veer_lft;
  logic        turn_180;
  logic        buzz_en;
  logic        busy;
`ifdef MAZE_PLAN_TIMEOUT_EN
  logic        fault;
`endif

  modport master (
    output cmd, cmd_rdy, line_present, bmp,
    input  clr_cmd_rdy, go, veer_rght, veer_lft, turn_180, buzz_en, busy
`ifdef MAZE_PLAN_TIMEOUT_EN
    , input fault
`endif
  );

  modport slave (
    input  cmd, cmd_rdy, line_present, bmp,
    output clr_cmd_rdy, go, veer_rght, veer_lft, turn_180, buzz_en, busy
`ifdef MAZE_PLAN_TIMEOUT_EN
    , output fault
`endif
  );
endinterface

// File: rtl/maze_plan_seq.sv
// Travel-plan sequencer: walks eight 2-bit maneuver codes, one per line gap, pausing on bumper hits.
// Optional MANEUVER timeout with sticky fault output is enabled by defining MAZE_PLAN_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for a travel plan word
// FOLLOW   | following the line, watching for a gap
// MANEUVER | executing the current code until the line is reacquired
// BUMP     | paused on a bumper hit, buzzer on
module maze_plan_seq #(
  parameter int GAP_CYC     = 4096,
  parameter int REACQ_CYC   = 4096
`ifdef MAZE_PLAN_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4000000
`endif
) (
  input logic        clk,
  input logic        rst,
  maze_plan_if.slave bus
);
  localparam int GW = $clog2(GAP_CYC);
  localparam int RW = $clog2(REACQ_CYC);
  localparam logic [GW-1:0] GAP_TC   = GW'(GAP_CYC - 1);
  localparam logic [RW-1:0] REACQ_TC = RW'(REACQ_CYC - 1);
`ifdef MAZE_PLAN_TIMEOUT_EN
  localparam int DW = $clog2(TIMEOUT_CYC);
  localparam logic [DW-1:0] DWELL_TC = DW'(TIMEOUT_CYC - 1);
  logic [DW-1:0] dwell_q, dwell_d;
  logic          fault_q, fault_d;
`endif

  typedef enum logic [1:0] {IDLE, FOLLOW, MANEUVER, BUMP} state_t;

  state_t        state_q, state_d, ret_q, ret_d;
  logic [15:0]   plan_q, plan_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [RW-1:0] reacq_q, reacq_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      plan_q  <= '0;
      gap_q   <= '0;
      reacq_q <= '0;
`ifdef MAZE_PLAN_TIMEOUT_EN
      dwell_q <= '0;
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      plan_q  <= plan_d;
      gap_q   <= gap_d;
      reacq_q <= reacq_d;
`ifdef MAZE_PLAN_TIMEOUT_EN
      dwell_q <= dwell_d;
      fault_q <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    plan_d  = plan_q;
    gap_d   = gap_q;
    reacq_d = reacq_q;
`ifdef MAZE_PLAN_TIMEOUT_EN
    dwell_d = dwell_q;
    fault_d = fault_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.cmd_rdy) begin
          plan_d  = bus.cmd;
          gap_d   = '0;
          reacq_d = '0;
          state_d = FOLLOW;
`ifdef MAZE_PLAN_TIMEOUT_EN
          fault_d = 1'b0;
`endif
        end
      end
      FOLLOW: begin
        if (bus.bmp) begin
          ret_d   = FOLLOW;
          state_d = BUMP;
        end else if (bus.line_present) begin
          gap_d = '0;
        end else if (gap_q == GAP_TC) begin
          if (plan_q[1:0] == 2'b00) begin
            gap_d   = '0;
            state_d = IDLE;
          end else begin
            reacq_d = '0;
            state_d = MANEUVER;
`ifdef MAZE_PLAN_TIMEOUT_EN
            dwell_d = '0;
`endif
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      MANEUVER: begin
        if (bus.bmp) begin
          ret_d   = MANEUVER;
          state_d = BUMP;
        end
`ifdef MAZE_PLAN_TIMEOUT_EN
        else if (dwell_q == DWELL_TC) begin
          gap_d   = '0;
          reacq_d = '0;
          fault_d = 1'b1;
          state_d = IDLE;
        end
`endif
        else begin
`ifdef MAZE_PLAN_TIMEOUT_EN
          dwell_d = dwell_q + DW'(1);
`endif
          if (!bus.line_present) begin
            reacq_d = '0;
          end else if (reacq_q == REACQ_TC) begin
            plan_d  = {2'b00, plan_q[15:2]};
            gap_d   = '0;
            reacq_d = '0;
            state_d = FOLLOW;
          end else begin
            reacq_d = reacq_q + RW'(1);
          end
        end
      end
      default: begin
        // counters hold their values while paused
        if (!bus.bmp) state_d = ret_q;
      end
    endcase
  end

  assign bus.clr_cmd_rdy = !rst && (state_q == IDLE) && bus.cmd_rdy;
  assign bus.go          = (state_q == FOLLOW) || (state_q == MANEUVER);
  assign bus.veer_rght   = (state_q == MANEUVER) && (plan_q[1:0] == 2'b01);
  assign bus.veer_lft    = (state_q == MANEUVER) && (plan_q[1:0] == 2'b10);
  assign bus.turn_180    = (state_q == MANEUVER) && (plan_q[1:0] == 2'b11);
  assign bus.buzz_en     = (state_q == BUMP);
  assign bus.busy        = (state_q != IDLE);
`ifdef MAZE_PLAN_TIMEOUT_EN
  assign bus.fault       = fault_q;
`endif
endmodule

// File: tb/tb_maze_plan_seq.sv
// Self-checking bench for maze_plan_seq against a run-length/queue reference model.
// Define MAZE_PLAN_TIMEOUT_EN to also exercise the MANEUVER timeout and fault output.
module tb_maze_plan_seq;
  localparam int GAP   = 16;
  localparam int REACQ = 12;
`ifdef MAZE_PLAN_TIMEOUT_EN
  localparam int TMO   = 200;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  maze_plan_if bus ();

  maze_plan_seq #(
    .GAP_CYC(GAP),
    .REACQ_CYC(REACQ)
`ifdef MAZE_PLAN_TIMEOUT_EN
    , .TIMEOUT_CYC(TMO)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int errors = 0;
  int checks = 0;

  // current input values, remembered for the model update at the next edge
  bit          in_rst, in_line, in_bmp, in_cr;
  logic [15:0] in_cmd;

  // reference model: plan as a queue of codes, gap/reacquire as run lengths
  bit m_active, m_turn, m_pause, m_fault;
  int m_dark, m_lit, m_dwell;
  int m_plan[$];

  initial begin
    bus.cmd = '0; bus.cmd_rdy = 0; bus.line_present = 1; bus.bmp = 0;
  end

  task automatic drive(input bit r, input bit ln, input bit b, input bit cr, input logic [15:0] c);
    @(negedge clk);
    in_rst = r; in_line = ln; in_bmp = b; in_cr = cr; in_cmd = c;
    rst = r; bus.line_present = ln; bus.bmp = b; bus.cmd_rdy = cr; bus.cmd = c;
    #1;
  endtask

  task automatic adv();
    bit timed_out;
    @(posedge clk);
    timed_out = 0;
    if (in_rst) begin
      m_active = 0; m_turn = 0; m_pause = 0; m_fault = 0;
      m_dark = 0; m_lit = 0; m_dwell = 0;
      m_plan.delete();
      for (int i = 0; i < 8; i++) m_plan.push_back(0);
    end else if (!m_active) begin
      if (in_cr) begin
        m_plan.delete();
        for (int i = 0; i < 8; i++) m_plan.push_back(int'((in_cmd >> (2 * i)) & 16'h3));
        m_active = 1; m_turn = 0; m_pause = 0; m_fault = 0; m_dark = 0; m_lit = 0;
      end
    end else if (m_pause) begin
      if (!in_bmp) m_pause = 0;
    end else if (in_bmp) begin
      m_pause = 1;
    end else if (!m_turn) begin
      if (in_line) m_dark = 0;
      else if (m_dark + 1 >= GAP) begin
        m_dark = 0;
        if (m_plan[0] == 0) m_active = 0;
        else begin m_turn = 1; m_lit = 0; m_dwell = 0; end
      end else m_dark++;
    end else begin
`ifdef MAZE_PLAN_TIMEOUT_EN
      m_dwell++;
      if (m_dwell >= TMO) begin timed_out = 1; m_active = 0; m_turn = 0; m_fault = 1; end
`endif
      if (!timed_out) begin
        if (!in_line) m_lit = 0;
        else if (m_lit + 1 >= REACQ) begin
          void'(m_plan.pop_front()); m_plan.push_back(0);
          m_turn = 0; m_lit = 0; m_dark = 0;
        end else m_lit++;
      end
    end
  endtask

  function automatic logic [7:0] model_vec();
    bit g;
    int code;
    code = (m_plan.size() > 0) ? m_plan[0] : 0;
    g = m_active && !m_pause;
    return {!in_rst && !m_active && in_cr, g, g && m_turn && code == 1, g && m_turn && code == 2,
            g && m_turn && code == 3, m_active && m_pause, m_active, m_fault};
  endfunction

  function automatic logic [7:0] dut_vec();
`ifdef MAZE_PLAN_TIMEOUT_EN
    return {bus.clr_cmd_rdy, bus.go, bus.veer_rght, bus.veer_lft, bus.turn_180, bus.buzz_en, bus.busy, bus.fault};
`else
    return {bus.clr_cmd_rdy, bus.go, bus.veer_rght, bus.veer_lft, bus.turn_180, bus.buzz_en, bus.busy, 1'b0};
`endif
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 16'h1234);
      checks++;
      if (dut_vec() !== 8'h00) begin errors++; $display("FAIL reset_outputs dut=%b want=%b", dut_vec(), 8'h00); end
      adv();
    end
    drive(0, 1, 0, 1, 16'h0001);
    checks++;
    if (bus.clr_cmd_rdy !== 1'b1 || bus.go !== 1'b0) begin
      errors++; $display("FAIL reset_accept clr=%b go=%b want clr=1 go=0", bus.clr_cmd_rdy, bus.go);
    end
    adv();
    drive(0, 1, 0, 0, 16'h0001);
    checks++;
    if (bus.clr_cmd_rdy !== 1'b0 || bus.go !== 1'b1) begin
      errors++; $display("FAIL reset_go clr=%b go=%b want clr=0 go=1", bus.clr_cmd_rdy, bus.go);
    end
    adv();
  endtask

  task automatic test_veer_right();
    int rise = -1, fall = -1, rise2 = -1;
    drive(1, 1, 0, 0, 0); adv();
    drive(0, 1, 0, 1, 16'h5555); adv();
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 0, 0); adv(); end
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0);
      checks++;
      if (dut_vec() !== model_vec()) begin errors++; $display("FAIL veer_gap i=%0d dut=%b model=%b", i, dut_vec(), model_vec()); end
      if (bus.veer_rght === 1'b1 && rise < 0) rise = i;
      adv();
    end
    for (int i = 0; i < REACQ + 4; i++) begin
      drive(0, 1, 0, 0, 0);
      checks++;
      if (dut_vec() !== model_vec()) begin errors++; $display("FAIL veer_reacq i=%0d dut=%b model=%b", i, dut_vec(), model_vec()); end
      if (bus.veer_rght === 1'b0 && fall < 0) fall = i;
      adv();
    end
    for (int i = 0; i < 20; i++) begin
      drive(0, 0, 0, 0, 0);
      if (bus.veer_rght === 1'b1 && rise2 < 0) rise2 = i;
      adv();
    end
    checks++;
    if (rise !== GAP) begin errors++; $display("FAIL veer_rise got=%0d want=%0d", rise, GAP); end
    checks++;
    if (fall !== REACQ) begin errors++; $display("FAIL veer_fall got=%0d want=%0d", fall, REACQ); end
    checks++;
    if (rise2 !== GAP) begin errors++; $display("FAIL veer_second got=%0d want=%0d", rise2, GAP); end
  endtask

  task automatic test_sequence();
    int got[$];
    int want[3] = '{1, 3, 2};
    bit seen;
    drive(1, 1, 0, 0, 0); adv();
    drive(0, 1, 0, 1, 16'h002D); adv();
    for (int g = 0; g < 4; g++) begin
      seen = 0;
      for (int i = 0; i < GAP + 4 + REACQ + 3; i++) begin
        drive(0, i >= GAP + 4, 0, 0, 0);
        checks++;
        if (dut_vec() !== model_vec()) begin errors++; $display("FAIL seq g=%0d i=%0d dut=%b model=%b", g, i, dut_vec(), model_vec()); end
        if (!seen && (bus.veer_rght | bus.veer_lft | bus.turn_180) === 1'b1) begin
          seen = 1;
          got.push_back(bus.veer_rght ? 1 : bus.veer_lft ? 2 : 3);
        end
        adv();
      end
    end
    checks++;
    if (got.size() != 3) begin errors++; $display("FAIL seq_count got=%0d want=3", got.size()); end
    for (int k = 0; k < 3 && k < got.size(); k++) begin
      checks++;
      if (got[k] != want[k]) begin errors++; $display("FAIL seq_code k=%0d got=%0d want=%0d", k, got[k], want[k]); end
    end
    drive(0, 1, 0, 0, 0);
    checks++;
    if (bus.go !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL seq_stop go=%b busy=%b want 0 0", bus.go, bus.busy); end
    adv();
  endtask

  task automatic test_gap_boundary();
    drive(1, 1, 0, 0, 0); adv();
    drive(0, 1, 0, 1, 16'h0000); adv();
    for (int i = 0; i < GAP - 1; i++) begin drive(0, 0, 0, 0, 0); adv(); end
    for (int i = 0; i < 3; i++) begin drive(0, 1, 0, 0, 0); adv(); end
    drive(0, 1, 0, 0, 0);
    checks++;
    if (bus.go !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL gap_short go=%b busy=%b want 1 1", bus.go, bus.busy); end
    adv();
    for (int i = 0; i < GAP; i++) begin drive(0, 0, 0, 0, 0); adv(); end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (bus.go !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL gap_full go=%b busy=%b want 0 0", bus.go, bus.busy); end
    adv();
  endtask

  task automatic test_bump();
    int hi = 0;
    drive(1, 1, 0, 0, 0); adv();
    drive(0, 1, 0, 1, 16'h0003); adv();
    for (int i = 0; i < GAP + 2; i++) begin drive(0, 0, 0, 0, 0); adv(); end
    for (int i = 0; i < 5; i++) begin drive(0, 1, 0, 0, 0); adv(); end
    for (int i = 0; i < 100; i++) begin
      drive(0, i[0], 1, i < 50, 16'hABCD);
      checks++;
      if (dut_vec() !== model_vec()) begin errors++; $display("FAIL bump i=%0d dut=%b model=%b", i, dut_vec(), model_vec()); end
      adv();
    end
    drive(0, 1, 0, 0, 0);
    checks++;
    if ({bus.go, bus.turn_180, bus.buzz_en} !== 3'b001) begin
      errors++; $display("FAIL bump_hold go/t180/buzz=%b want 001", {bus.go, bus.turn_180, bus.buzz_en});
    end
    adv();
    for (int i = 0; i < REACQ + 5; i++) begin
      drive(0, 1, 0, 0, 0);
      checks++;
      if (dut_vec() !== model_vec()) begin errors++; $display("FAIL bump_resume i=%0d dut=%b model=%b", i, dut_vec(), model_vec()); end
      if (bus.turn_180 === 1'b1) hi++;
      adv();
    end
    checks++;
    if (hi != REACQ - 5) begin errors++; $display("FAIL bump_reacq got=%0d want=%0d", hi, REACQ - 5); end
  endtask

  task automatic test_random();
    int run_left = 0, bmp_left = 0;
    bit ln = 1, b, r, cr;
    drive(1, 1, 0, 0, 0); adv();
    for (int i = 0; i < 4000; i++) begin
      if (run_left == 0) begin
        ln = !ln;
        run_left = ln ? $urandom_range(1, REACQ + 6) : $urandom_range(1, GAP + 6);
      end
      run_left--;
      if (bmp_left == 0 && $urandom_range(0, 59) == 0) bmp_left = $urandom_range(1, 8);
      b = bmp_left > 0;
      if (bmp_left > 0) bmp_left--;
      r = ($urandom_range(0, 699) == 0);
      cr = $urandom_range(0, 1);
      drive(r, ln, b, cr, 16'($urandom));
      checks++;
      if (dut_vec() !== model_vec()) begin errors++; $display("FAIL random i=%0d dut=%b model=%b", i, dut_vec(), model_vec()); end
      adv();
    end
  endtask

`ifdef MAZE_PLAN_TIMEOUT_EN
  task automatic test_timeout();
    int hi = 0;
    drive(1, 1, 0, 0, 0); adv();
    drive(0, 1, 0, 1, 16'hFFFF); adv();
    for (int i = 0; i < GAP + TMO + 10; i++) begin
      drive(0, 0, 0, 0, 0);
      checks++;
      if (dut_vec() !== model_vec()) begin errors++; $display("FAIL timeout i=%0d dut=%b model=%b", i, dut_vec(), model_vec()); end
      if (bus.turn_180 === 1'b1) hi++;
      adv();
    end
    checks++;
    if (hi != TMO) begin errors++; $display("FAIL timeout_len got=%0d want=%0d", hi, TMO); end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (bus.fault !== 1'b1 || bus.go !== 1'b0) begin errors++; $display("FAIL timeout_fault fault=%b go=%b want 1 0", bus.fault, bus.go); end
    adv();
    drive(0, 1, 0, 1, 16'h0001); adv();
    drive(0, 1, 0, 0, 0);
    checks++;
    if (bus.fault !== 1'b0) begin errors++; $display("FAIL fault_clear fault=%b want 0", bus.fault); end
    adv();
  endtask
`endif

  initial begin
    test_reset();
    test_veer_right();
    test_sequence();
    test_gap_boundary();
    test_bump();
`ifdef MAZE_PLAN_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/maze_plan_seq.md
Name: maze_plan_seq

Overview:
- Travel-plan sequencer inside MazeRunner, directly downstream of the UART wrapper.
- Consumes the 16-bit travel-plan word (eight 2-bit maneuver codes, LSB pair first) and drives the line-follow controller with go/maneuver requests at each line gap.
- Pauses motion and enables the buzzer on a bumper hit.

Parameters:
- GAP_CYC, 4096, consecutive cycles of line_present=0 required to declare a gap.
- REACQ_CYC, 4096, consecutive cycles of line_present=1 required to declare the line reacquired after a maneuver.
- TIMEOUT_CYC, 4000000, maximum cycles in MANEUVER (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd  in  16  travel plan from UART wrapper
- cmd_rdy  in  1  cmd valid (level, held until cleared)
- clr_cmd_rdy  out  1  one-cycle pulse acknowledging cmd
- line_present  in  1  IR line sensed
- bmp  in  1  OR of debounced, active-high bumper hits
- go  out  1  enable forward line following
- veer_rght  out  1  right-veer maneuver request (level)
- veer_lft  out  1  left-veer maneuver request (level)
- turn_180  out  1  turn-around request (level)
- buzz_en  out  1  enable piezo driver
- busy  out  1  plan in progress (state != IDLE)

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset: all outputs 0; plan register 0; counters 0; state IDLE. rst asserted mid-operation forces this state on the next edge, overriding all other inputs.
- Codes: 00 = stop; 01 = veer right; 10 = veer left; 11 = turn around.
- IDLE:
  - If cmd_rdy=1: latch cmd into plan, pulse clr_cmd_rdy for exactly one cycle, go FOLLOW.
  - go rises the cycle after acceptance.
  - bmp is ignored in IDLE.
- FOLLOW (go=1):
  - gap_cnt increments while line_present=0 and clears on line_present=1.
  - When gap_cnt reaches GAP_CYC-1 with line_present=0, examine plan[1:0]:
    - 00: go IDLE; go=0 next cycle.
    - Otherwise: go MANEUVER and assert the matching request output, exactly one of the three.
- MANEUVER (go=1, request held):
  - reacq_cnt counts consecutive line_present=1 cycles and clears on any 0.
  - At REACQ_CYC-1: drop the request, shift plan right by 2 with zero fill, clear counters, go FOLLOW.
  - After eight maneuvers the plan is all-zero, so the next gap stops the robot.
- BUMP, entered from FOLLOW or MANEUVER when bmp=1:
  - go=0, request outputs 0, buzz_en=1 from the next cycle.
  - Return state and plan are saved.
  - gap_cnt/reacq_cnt are frozen, not cleared.
  - On bmp=0: return to the saved state next cycle, buzz_en=0, and restore the request output.
- Priority:
  - bmp beats the gap or reacquire decision in the same cycle.
  - cmd_rdy while busy is ignored: no clr_cmd_rdy, and the word waits until IDLE.
- Counters saturate at their terminal value and never wrap. Counter widths are sized with $clog2 of the parameter.

Optional Feature:
- MAZE_PLAN_TIMEOUT_EN defined:
  - Adds output fault (1 bit, reset 0) and a MANEUVER dwell counter that freezes in BUMP.
  - If the counter reaches TIMEOUT_CYC-1, go IDLE with all requests/go 0 and fault=1.
  - fault is sticky until the next accepted cmd or rst.
- Undefined: no fault port and no dwell counter; MANEUVER may last indefinitely.

Test Plan:
- rst held, cmd_rdy=1 -> no clr_cmd_rdy, all outputs 0; release -> clr_cmd_rdy one cycle, go=1 the following cycle.
- cmd=16'h5555, gap of 5000 cycles -> veer_rght rises GAP_CYC cycles after line loss, falls 4096 cycles after line returns; plan becomes 16'h1555.
- cmd=16'h002D, four gaps -> request sequence veer_rght, turn_180, veer_lft; then go=0 at the 4th gap and busy=0.
- cmd=16'h0000, 4095-cycle dropout then line -> no stop; a 4096-cycle dropout -> go=0.
- In MANEUVER (turn_180), bmp=1 for 100 cycles -> go=0, turn_180=0, buzz_en=1; on release turn_180=1 and reacq_cnt resumes from its frozen value.
- With MAZE_PLAN_TIMEOUT_EN, cmd=16'hFFFF and line never returns -> fault=1 and go=0 after TIMEOUT_CYC MANEUVER cycles; new cmd clears fault.
